// File: rtl/mac_pe_pipe.sv
// Systolic MAC PE: forwards A east / B south and accumulates a*b; define MAC_PE_SAT_EN to saturate the accumulator.
// Forward path 1 cycle, input-to-result 2 cycles; no backpressure, a new sample may be accepted every cycle.
module mac_pe_pipe #(
  parameter int DW = 8,
  parameter int AW = 2*DW+4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] a_in,
  input  logic signed [DW-1:0] b_in,
  input  logic                 in_clr,
  input  logic                 in_last,
  output logic signed [DW-1:0] a_out,
  output logic signed [DW-1:0] b_out,
  output logic                 valid_out,
  output logic signed [AW-1:0] res,
  output logic                 res_valid,
  output logic                 res_ovf
);

  localparam int PW = 2*DW;

`ifdef MAC_PE_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};
`endif

  logic signed [DW-1:0] a_fwd_q, a_fwd_d;
  logic signed [DW-1:0] b_fwd_q, b_fwd_d;
  logic                 v_fwd_q, v_fwd_d;

  logic                 vld1_q, vld1_d;
  logic signed [PW-1:0] prod1_q, prod1_d;
  logic                 clr1_q, clr1_d;
  logic                 last1_q, last1_d;

  logic signed [AW-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic signed [AW-1:0] res_q, res_d;
  logic                 res_vld_q, res_vld_d;
  logic                 res_ovf_q, res_ovf_d;

  logic signed [AW-1:0] acc_base;
  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] acc_next;
  logic                 add_ovf;
  logic                 ovf_next;

  always_comb begin
    a_fwd_d = a_in;
    b_fwd_d = b_in;
    v_fwd_d = in_valid;

    // clr/last only mean something on a qualified sample
    vld1_d  = in_valid;
    prod1_d = prod1_q;
    clr1_d  = 1'b0;
    last1_d = 1'b0;
    if (in_valid) begin
      prod1_d = PW'(a_in) * PW'(b_in);
      clr1_d  = in_clr;
      last1_d = in_last;
    end
  end

  always_comb begin
    acc_base = clr1_q ? '0 : acc_q;
    prod_ext = AW'(prod1_q);
    sum      = acc_base + prod_ext;
    add_ovf  = (acc_base[AW-1] == prod_ext[AW-1]) && (sum[AW-1] != acc_base[AW-1]);
    acc_next = sum;
`ifdef MAC_PE_SAT_EN
    // both operands share a sign on overflow, so the base sign picks the rail
    if (add_ovf) begin
      acc_next = acc_base[AW-1] ? SAT_MIN : SAT_MAX;
    end
`endif
    ovf_next = (~clr1_q & ovf_q) | add_ovf;

    acc_d     = acc_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    res_ovf_d = res_ovf_q;
    res_vld_d = 1'b0;
    if (vld1_q) begin
      acc_d = acc_next;
      ovf_d = ovf_next;
      if (last1_q) begin
        res_d     = acc_next;
        res_ovf_d = ovf_next;
        res_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_fwd_q   <= '0;
      b_fwd_q   <= '0;
      v_fwd_q   <= 1'b0;
      vld1_q    <= 1'b0;
      prod1_q   <= '0;
      clr1_q    <= 1'b0;
      last1_q   <= 1'b0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      res_ovf_q <= 1'b0;
    end else begin
      a_fwd_q   <= a_fwd_d;
      b_fwd_q   <= b_fwd_d;
      v_fwd_q   <= v_fwd_d;
      vld1_q    <= vld1_d;
      prod1_q   <= prod1_d;
      clr1_q    <= clr1_d;
      last1_q   <= last1_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign a_out     = a_fwd_q;
  assign b_out     = b_fwd_q;
  assign valid_out = v_fwd_q;
  assign res       = res_q;
  assign res_valid = res_vld_q;
  assign res_ovf   = res_ovf_q;

endmodule
